arm_multicycle_ctrl: RTL and testbench
======================================

# arm_multicycle_ctrl

Control unit for the multicycle variant of the ARM processor. It sequences each instruction through fetch, decode, execute, memory and writeback over multiple clock cycles, and holds the NZCV flags for conditional execution. It drives the shared-datapath selects, including `ImmSrc` to the immediate extender, and all architectural write enables.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces FETCH, clears flags and CondExReg
- `Cond`  in  4  Instr[31:28]
- `Op`  in  2  Instr[27:26]
- `Funct`  in  6  Instr[25:20]
- `Rd`  in  4  Instr[15:12]
- `ALUFlags`  in  4  {N,Z,C,V} from ALU, current cycle
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite`  out  1  write enables
- `AdrSrc`  out  1  0=PC, 1=ALUResult reg
- `ALUSrcA`  out  1  0=RD1 reg, 1=PC
- `ALUSrcB`  out  2  00=RD2 reg, 01=ExtImm, 10=const 4
- `ResultSrc`  out  2  00=ALUOut reg, 01=Data reg, 10=ALUResult
- `ImmSrc`  out  2  =Op, combinational (00 imm8, 01 imm12, 10 imm24<<2)
- `RegSrc`  out  2  [0]=(Op==10), [1]=(Op==01)
- `ALUControl`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- State register, 11 states; unlisted outputs are 0. Transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1 -> DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; latch CondExReg. Next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: ALUSrcA=0, ALUSrcB=01. Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW=1 -> FETCH.
  - MEMWR: AdrSrc=1, MemW=1 -> FETCH.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1 -> ALUWB. EXECUTEI: same with ALUSrcB=01 -> ALUWB.
  - ALUWB: ResultSrc=00, RegW=1 -> FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
  - UNKNOWN: no writes -> FETCH.
- ALU decode applies only when ALUOp=1. Funct[4:1] maps 0100 to ADD, 0010 to SUB, 0000 to AND and 1100 to ORR; any other value gives ADD with FlagW=00. FlagW[1]=Funct[0]. FlagW[0]=Funct[0]&(ADD|SUB). When ALUOp=0: ALUControl=00, FlagW=00.
- Condition check uses stored flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
- CondExReg is loaded at the DECODE edge and holds for the rest of the instruction. Flags updated in EXECUTE therefore do not alter the instruction's own writeback.
- PCS = (Rd==1111 & RegW) | Branch.
- PCWrite = NextPC | (PCS & CondExReg).
- RegWrite = RegW & CondExReg. MemWrite = MemW & CondExReg.
- Flags update at the clock edge when CondExReg is set. FlagW[1] loads N,Z from ALUFlags[3:2]. FlagW[0] loads C,V from ALUFlags[1:0].

## Timing
- Reset asynchronous: state=FETCH, Flags=0000, CondExReg=0 immediately. PCWrite, IRWrite, RegWrite and MemWrite are forced 0 while reset is high. The first fetch occurs in the first cycle after reset deasserts.
- Outputs are Moore decodes of state, except ImmSrc, RegSrc, PCS and ALUControl, which also depend on instruction fields.
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, Op=11 3. Cycle counts are identical when the condition fails.
- Reset asserted mid-instruction: any pending write is suppressed in that cycle, and the next instruction starts from FETCH.
- ADD R15 with condition passing: PCWrite pulses in ALUWB in addition to FETCH.

## Test plan
- Reset then ADD R1,R2,R3 with Cond=1110: states FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 only in ALUWB. PCWrite=1 only in FETCH.
- LDR then STR: the LDR gives RegWrite=1 in cycle 5 with ResultSrc=01. The STR gives MemWrite=1 in cycle 4 with AdrSrc=1 and RegWrite never set.
- SUBS with ALUFlags=0100, then ADDEQ: Flags=0100 after EXECUTER. The ADDEQ asserts RegWrite. An ADDNE that follows asserts no writes but still takes 4 cycles.
- B with Cond=1110: ImmSrc=10, RegSrc=01, and PCWrite=1 in the BRANCH state. BNE with Z=1: no PCWrite in BRANCH.
- ANDS then ADD (S=0): the ANDS with ALUFlags=1011 updates only NZ (Flags=10xx, C and V preserved). The ADD leaves all flags unchanged.
- Assert reset during MEMWR: MemWrite=0 in the same cycle, state=FETCH, Flags=0000. Op=11 passes through UNKNOWN with no writes.

Source files
------------

// File: rtl/arm_multicycle_ctrl.sv
// ============================================================================
// arm_multicycle_ctrl : multicycle ARM control FSM with NZCV flags and cond-ex
// Revision: 1.0
// ============================================================================
`default_nettype none

module arm_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] flags;
  logic       cond_ex_reg;

  logic       next_pc;
  logic       reg_w;
  logic       mem_w;
  logic       ir_w;
  logic       branch;
  logic       alu_op;
  logic [1:0] flag_w;
  logic       cond_ex;
  logic       pcs;
  logic       funct_known;
  logic       funct_addsub;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Condition is frozen at DECODE so flag updates in EXECUTE never gate
  // the same instruction's writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      if (state == S_DECODE) cond_ex_reg <= cond_ex;
      if (cond_ex_reg && flag_w[1]) flags[3:2] <= ALUFlags[3:2];
      if (cond_ex_reg && flag_w[0]) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_next = state;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      S_FETCH: begin
        ir_w       = 1'b1;
        next_pc    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_op     = 1'b1;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        alu_op     = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ALUControl   = 2'b00;
    funct_known  = 1'b0;
    funct_addsub = 1'b0;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; funct_known = 1'b1; funct_addsub = 1'b1; end
        4'b0010: begin ALUControl = 2'b01; funct_known = 1'b1; funct_addsub = 1'b1; end
        4'b0000: begin ALUControl = 2'b10; funct_known = 1'b1; end
        4'b1100: begin ALUControl = 2'b11; funct_known = 1'b1; end
        default: ALUControl = 2'b00;
      endcase
    end
    flag_w = funct_known ? {Funct[0], Funct[0] & funct_addsub} : 2'b00;
  end

  always_comb begin
    case (Cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign pcs    = ((Rd == 4'b1111) & reg_w) | branch;
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

  // Write enables are masked while reset is high so an in-flight write cannot land.
  assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex_reg));
  assign RegWrite = ~reset & reg_w & cond_ex_reg;
  assign MemWrite = ~reset & mem_w & cond_ex_reg;
  assign IRWrite  = ~reset & ir_w;

endmodule

`default_nettype wire

// File: tb/tb_arm_multicycle_ctrl.sv
// ============================================================================
// tb_arm_multicycle_ctrl : directed self-checking bench for arm_multicycle_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arm_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  int checks = 0;
  int errors = 0;

  arm_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
    #1;
  endtask

  function automatic logic [3:0] wr();
    return {PCWrite, MemWrite, RegWrite, IRWrite};
  endfunction

  task automatic test_reset();
    reset = 1'b1; ALUFlags = 4'b1111;
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd0);
    tick(); tick();
    checks++; if (wr() !== 4'b0000) begin errors++; $display("FAIL reset_wen: got %b expected 0000", wr()); end
    checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b11010) begin errors++; $display("FAIL reset_fetch_sel: got %b expected 11010", {ALUSrcA, ALUSrcB, ResultSrc}); end
    checks++; if (dut.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", dut.flags); end
    reset = 1'b0;
    #1;
    checks++; if (wr() !== 4'b1001) begin errors++; $display("FAIL reset_first_fetch: got %b expected 1001", wr()); end
  endtask

  task automatic test_add();
    logic [3:0] exp [0:3] = '{4'b1001, 4'b0000, 4'b0000, 4'b0010};
    set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
    ALUFlags = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      checks++; if (wr() !== exp[c]) begin errors++; $display("FAIL add_wen cycle %0d: got %b expected %b", c, wr(), exp[c]); end
      if (c == 2) begin
        checks++; if ({ALUSrcA, ALUSrcB, ALUControl} !== 5'b00000) begin errors++; $display("FAIL add_exec_sel: got %b expected 00000", {ALUSrcA, ALUSrcB, ALUControl}); end
      end
      if (c == 3) begin
        checks++; if (ResultSrc !== 2'b00) begin errors++; $display("FAIL add_aluwb_res: got %b expected 00", ResultSrc); end
      end
      tick();
    end
    checks++; if (dut.flags !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b expected 0000", dut.flags); end
  endtask

  task automatic test_ldr_str();
    logic [3:0] exl [0:4] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    logic [3:0] exs [0:3] = '{4'b1001, 4'b0000, 4'b0000, 4'b0100};
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd2);
    for (int c = 0; c < 5; c++) begin
      checks++; if (wr() !== exl[c]) begin errors++; $display("FAIL ldr_wen cycle %0d: got %b expected %b", c, wr(), exl[c]); end
      if (c == 1) begin
        checks++; if ({ImmSrc, RegSrc} !== 4'b0110) begin errors++; $display("FAIL ldr_imm_reg: got %b expected 0110", {ImmSrc, RegSrc}); end
      end
      if (c == 3) begin
        checks++; if (AdrSrc !== 1'b1) begin errors++; $display("FAIL ldr_memrd_adr: got %b expected 1", AdrSrc); end
      end
      if (c == 4) begin
        checks++; if (ResultSrc !== 2'b01) begin errors++; $display("FAIL ldr_memwb_res: got %b expected 01", ResultSrc); end
      end
      tick();
    end
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd3);
    for (int c = 0; c < 4; c++) begin
      checks++; if (wr() !== exs[c]) begin errors++; $display("FAIL str_wen cycle %0d: got %b expected %b", c, wr(), exs[c]); end
      if (c == 2) begin
        checks++; if ({ALUSrcA, ALUSrcB} !== 3'b001) begin errors++; $display("FAIL str_memadr_sel: got %b expected 001", {ALUSrcA, ALUSrcB}); end
      end
      if (c == 3) begin
        checks++; if (AdrSrc !== 1'b1) begin errors++; $display("FAIL str_memwr_adr: got %b expected 1", AdrSrc); end
      end
      tick();
    end
  endtask

  task automatic test_flags_cond();
    logic [3:0] exs [0:3] = '{4'b1001, 4'b0000, 4'b0000, 4'b0010};
    logic [3:0] exn [0:3] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000};
    set_instr(4'b1110, 2'b00, 6'b000101, 4'd4);
    ALUFlags = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      checks++; if (wr() !== exs[c]) begin errors++; $display("FAIL subs_wen cycle %0d: got %b expected %b", c, wr(), exs[c]); end
      if (c == 2) begin
        checks++; if (ALUControl !== 2'b01) begin errors++; $display("FAIL subs_aluctl: got %b expected 01", ALUControl); end
      end
      if (c == 3) begin
        checks++; if (dut.flags !== 4'b0100) begin errors++; $display("FAIL subs_flags: got %b expected 0100", dut.flags); end
      end
      tick();
    end
    ALUFlags = 4'b0000;
    set_instr(4'b0000, 2'b00, 6'b001000, 4'd5);
    for (int c = 0; c < 4; c++) begin
      checks++; if (wr() !== exs[c]) begin errors++; $display("FAIL addeq_wen cycle %0d: got %b expected %b", c, wr(), exs[c]); end
      tick();
    end
    set_instr(4'b0001, 2'b00, 6'b001000, 4'd6);
    for (int c = 0; c < 4; c++) begin
      checks++; if (wr() !== exn[c]) begin errors++; $display("FAIL addne_wen cycle %0d: got %b expected %b", c, wr(), exn[c]); end
      tick();
    end
    checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL addne_cycles: IRWrite got %b expected 1", IRWrite); end
  endtask

  task automatic test_branch();
    logic [3:0] exb [0:2] = '{4'b1001, 4'b0000, 4'b1000};
    logic [3:0] exn [0:2] = '{4'b1001, 4'b0000, 4'b0000};
    set_instr(4'b1110, 2'b10, 6'b101000, 4'd0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (wr() !== exb[c]) begin errors++; $display("FAIL b_wen cycle %0d: got %b expected %b", c, wr(), exb[c]); end
      if (c == 0) begin
        checks++; if ({ImmSrc, RegSrc} !== 4'b1001) begin errors++; $display("FAIL b_imm_reg: got %b expected 1001", {ImmSrc, RegSrc}); end
      end
      if (c == 2) begin
        checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b00110) begin errors++; $display("FAIL b_branch_sel: got %b expected 00110", {ALUSrcA, ALUSrcB, ResultSrc}); end
      end
      tick();
    end
    set_instr(4'b0001, 2'b10, 6'b101000, 4'd0);
    for (int c = 0; c < 3; c++) begin
      checks++; if (wr() !== exn[c]) begin errors++; $display("FAIL bne_wen cycle %0d: got %b expected %b", c, wr(), exn[c]); end
      tick();
    end
  endtask

  task automatic test_nz_only();
    ALUFlags = 4'b0110;
    set_instr(4'b1110, 2'b00, 6'b001001, 4'd1);
    repeat (4) tick();
    checks++; if (dut.flags !== 4'b0110) begin errors++; $display("FAIL adds_flags: got %b expected 0110", dut.flags); end
    ALUFlags = 4'b1011;
    set_instr(4'b1110, 2'b00, 6'b000001, 4'd1);
    tick(); tick();
    checks++; if (ALUControl !== 2'b10) begin errors++; $display("FAIL ands_aluctl: got %b expected 10", ALUControl); end
    tick(); tick();
    checks++; if (dut.flags !== 4'b1010) begin errors++; $display("FAIL ands_flags: got %b expected 1010", dut.flags); end
    ALUFlags = 4'b0101;
    set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
    repeat (4) tick();
    checks++; if (dut.flags !== 4'b1010) begin errors++; $display("FAIL add_nos_flags: got %b expected 1010", dut.flags); end
  endtask

  task automatic test_alu_decode();
    logic [3:0] exp [0:3] = '{4'b1001, 4'b0000, 4'b0000, 4'b1010};
    ALUFlags = 4'b0101;
    set_instr(4'b1110, 2'b00, 6'b011000, 4'd1);
    tick(); tick();
    checks++; if (ALUControl !== 2'b11) begin errors++; $display("FAIL orr_aluctl: got %b expected 11", ALUControl); end
    tick(); tick();
    set_instr(4'b1110, 2'b00, 6'b011111, 4'd1);
    tick(); tick();
    checks++; if (ALUControl !== 2'b00) begin errors++; $display("FAIL undef_aluctl: got %b expected 00", ALUControl); end
    tick(); tick();
    checks++; if (dut.flags !== 4'b1010) begin errors++; $display("FAIL undef_flags: got %b expected 1010", dut.flags); end
    set_instr(4'b1110, 2'b00, 6'b001000, 4'd15);
    for (int c = 0; c < 4; c++) begin
      checks++; if (wr() !== exp[c]) begin errors++; $display("FAIL add_r15_wen cycle %0d: got %b expected %b", c, wr(), exp[c]); end
      tick();
    end
  endtask

  task automatic test_cond_table();
    logic [3:0] fl [0:11] = '{4'b1001, 4'b1001, 4'b0010, 4'b0010, 4'b0110, 4'b1000,
                              4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1000};
    logic [3:0] cd [0:11] = '{4'b1010, 4'b1011, 4'b1000, 4'b1001, 4'b1000, 4'b1100,
                              4'b1101, 4'b1100, 4'b0110, 4'b1111, 4'b0011, 4'b0101};
    logic       ex [0:11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      ALUFlags = fl[i];
      set_instr(4'b1110, 2'b00, 6'b001001, 4'd1);
      repeat (4) tick();
      ALUFlags = 4'b0000;
      set_instr(cd[i], 2'b00, 6'b001000, 4'd1);
      repeat (3) tick();
      checks++; if (RegWrite !== ex[i]) begin errors++; $display("FAIL cond_%0d flags %b cond %b: RegWrite got %b expected %b", i, fl[i], cd[i], RegWrite, ex[i]); end
      tick();
    end
  endtask

  task automatic test_unknown_op();
    logic [3:0] exp [0:2] = '{4'b1001, 4'b0000, 4'b0000};
    set_instr(4'b1110, 2'b11, 6'b111111, 4'd15);
    for (int c = 0; c < 3; c++) begin
      checks++; if (wr() !== exp[c]) begin errors++; $display("FAIL op11_wen cycle %0d: got %b expected %b", c, wr(), exp[c]); end
      tick();
    end
    checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL op11_cycles: IRWrite got %b expected 1", IRWrite); end
  endtask

  task automatic test_reset_midway();
    logic [3:0] exp [0:3] = '{4'b1001, 4'b0000, 4'b0000, 4'b0010};
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd3);
    repeat (3) tick();
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL memwr_before_reset: got %b expected 1", MemWrite); end
    reset = 1'b1;
    #1;
    checks++; if (wr() !== 4'b0000) begin errors++; $display("FAIL midreset_wen: got %b expected 0000", wr()); end
    checks++; if ({AdrSrc, ALUSrcB} !== 3'b010) begin errors++; $display("FAIL midreset_state: got %b expected 010", {AdrSrc, ALUSrcB}); end
    checks++; if ({dut.flags, dut.cond_ex_reg} !== 5'b00000) begin errors++; $display("FAIL midreset_flags: got %b expected 00000", {dut.flags, dut.cond_ex_reg}); end
    tick();
    reset = 1'b0;
    set_instr(4'b1110, 2'b00, 6'b001000, 4'd1);
    for (int c = 0; c < 4; c++) begin
      checks++; if (wr() !== exp[c]) begin errors++; $display("FAIL postreset_add cycle %0d: got %b expected %b", c, wr(), exp[c]); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; ALUFlags = 4'b0000;
    Cond = 4'b1110; Op = 2'b00; Funct = 6'b000000; Rd = 4'd0;
    @(negedge clk);
    #1;
    test_reset();
    test_add();
    test_ldr_str();
    test_flags_cond();
    test_branch();
    test_nz_only();
    test_alu_decode();
    test_cond_table();
    test_unknown_op();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
